// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state and owner codes for the data memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;
endpackage

// File: rtl/mem_arb_wait_ctr.sv
// mem_arb_wait_ctr: saturating count of DMA arbitration losses, flags when the DMA must be forced in.
module mem_arb_wait_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);
  localparam int W = $clog2(MAX_WAIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign at_max_o = cnt_q == W'(MAX_WAIT);
  always_comb cnt_d = clr_i ? '0 : (inc_i && !at_max_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i) begin
    if (!reset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data RAM between the CPU (priority) and DMA (bounded wait).
// Define MEM_ARB_STATS_EN to build the grant/conflict statistics counters; otherwise they read 0.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wd_i,
  output logic [DATA_W-1:0] cpu_rd_o,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wd_i,
  output logic [DATA_W-1:0] dma_rd_o,
  output logic              dma_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rd_i,
  output logic [CNT_W-1:0]  cpu_grant_cnt_o,
  output logic [CNT_W-1:0]  dma_grant_cnt_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);
  arb_state_t        state_q;
  logic              owner_q, we_q, cpu_ack_q, dma_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q, cpu_rd_q, dma_rd_q;
  logic              arb, cpu_elig, dma_elig, dma_win, grant, at_max;
  // The requester acked in RESP still shows its old req, so it sits out this round.
  assign arb      = state_q != BUSY;
  assign cpu_elig = cpu_req_i && !(state_q == RESP && owner_q == REQ_CPU);
  assign dma_elig = dma_req_i && !(state_q == RESP && owner_q == REQ_DMA);
  assign dma_win  = dma_elig && (at_max || !cpu_elig);
  assign grant    = arb && (cpu_elig || dma_elig);
  mem_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (arb && dma_req_i && !dma_win),
    .clr_i   (!dma_req_i || (arb && dma_win)),
    .at_max_o(at_max)
  );
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      owner_q   <= REQ_CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      cpu_rd_q  <= '0;
      dma_rd_q  <= '0;
    end else begin
      cpu_ack_q <= state_q == BUSY && owner_q == REQ_CPU;
      dma_ack_q <= state_q == BUSY && owner_q == REQ_DMA;
      if (state_q == BUSY) begin
        if (owner_q == REQ_CPU) cpu_rd_q <= mem_rd_i;
        else dma_rd_q <= mem_rd_i;
        state_q <= RESP;
      end else if (grant) begin
        state_q <= BUSY;
        owner_q <= dma_win ? REQ_DMA : REQ_CPU;
        we_q    <= dma_win ? dma_we_i : cpu_we_i;
        addr_q  <= dma_win ? dma_addr_i : cpu_addr_i;
        wd_q    <= dma_win ? dma_wd_i : cpu_wd_i;
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign mem_addr_o  = addr_q;
  assign mem_wd_o    = wd_q;
  assign mem_we_o    = state_q == BUSY && we_q;
  assign cpu_rd_o    = cpu_rd_q;
  assign dma_rd_o    = dma_rd_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign dma_ack_o   = dma_ack_q;
  assign cpu_stall_o = cpu_req_i && !cpu_ack_q;
`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] cpu_cnt_q, dma_cnt_q, cfl_cnt_q;
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cpu_cnt_q <= '0;
      dma_cnt_q <= '0;
      cfl_cnt_q <= '0;
    end else begin
      if (grant && !dma_win && !(&cpu_cnt_q)) cpu_cnt_q <= cpu_cnt_q + 1'b1;
      if (grant && dma_win && !(&dma_cnt_q)) dma_cnt_q <= dma_cnt_q + 1'b1;
      if (arb && cpu_elig && dma_elig && !(&cfl_cnt_q)) cfl_cnt_q <= cfl_cnt_q + 1'b1;
    end
  end
  assign cpu_grant_cnt_o = cpu_cnt_q;
  assign dma_grant_cnt_o = dma_cnt_q;
  assign conflict_cnt_o  = cfl_cnt_q;
`else
  assign cpu_grant_cnt_o = '0;
  assign dma_grant_cnt_o = '0;
  assign conflict_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_data_mem_arbiter;
  localparam int MW = 1;
`ifdef MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wd = '0, dma_addr = '0, dma_wd = '0;
  logic [31:0] cpu_rd, dma_rd, mem_addr, mem_wd, mem_rd;
  logic cpu_ack, cpu_stall, dma_ack, mem_we;
  logic [15:0] cpu_grant_cnt, dma_grant_cnt, conflict_cnt;
  logic [31:0] ram [64];
  logic [31:0] mmem [64];
  int total = 0, passed = 0;
  // model: who occupies the RAM this cycle, who is acked this cycle (-1 = nobody)
  int m_busy = -1, m_resp = -1, m_w = 0, m_cg = 0, m_dg = 0, m_cf = 0;
  logic m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wd = '0, m_cpu_rd = '0, m_dma_rd = '0;

  always #5 clk = ~clk;
  assign mem_rd = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wd;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wd_i(cpu_wd),
    .cpu_rd_o(cpu_rd), .cpu_ack_o(cpu_ack), .cpu_stall_o(cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wd_i(dma_wd),
    .dma_rd_o(dma_rd), .dma_ack_o(dma_ack),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_we_o(mem_we), .mem_rd_i(mem_rd),
    .cpu_grant_cnt_o(cpu_grant_cnt), .dma_grant_cnt_o(dma_grant_cnt), .conflict_cnt_o(conflict_cnt)
  );

  task automatic model_edge();
    logic ce, de;
    int win;
    if (!reset) begin
      if (m_busy >= 0 && m_we) mmem[m_addr[7:2]] = m_wd;
      m_busy = -1; m_resp = -1; m_w = 0; m_we = 1'b0; m_addr = '0; m_wd = '0;
      m_cpu_rd = '0; m_dma_rd = '0; m_cg = 0; m_dg = 0; m_cf = 0;
    end else if (m_busy >= 0) begin
      if (m_busy == 0) m_cpu_rd = mmem[m_addr[7:2]];
      else m_dma_rd = mmem[m_addr[7:2]];
      if (m_we) mmem[m_addr[7:2]] = m_wd;
      if (!dma_req) m_w = 0;
      m_resp = m_busy;
      m_busy = -1;
    end else begin
      ce = cpu_req && m_resp != 0;
      de = dma_req && m_resp != 1;
      win = (de && m_w >= MW) ? 1 : ce ? 0 : de ? 1 : -1;
      if (ce && de) m_cf++;
      m_w = (!dma_req || win == 1) ? 0 : (m_w < MW ? m_w + 1 : MW);
      if (win == 0) begin m_cg++; m_we = cpu_we; m_addr = cpu_addr; m_wd = cpu_wd; end
      if (win == 1) begin m_dg++; m_we = dma_we; m_addr = dma_addr; m_wd = dma_wd; end
      m_busy = win;
      m_resp = -1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ram(input int i, input logic [31:0] v);
    ram[i] = v;
    mmem[i] = v;
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_resp == 0) cpu_req = 1'b0;
      if (m_resp == 1) dma_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    tick(); tick();
    total++; if (cpu_ack !== 1'b0) $display("FAIL reset_cpu_ack got=%b exp=0", cpu_ack); else passed++;
    total++; if (dma_ack !== 1'b0) $display("FAIL reset_dma_ack got=%b exp=0", dma_ack); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got=%b exp=0", mem_we); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); else passed++;
    total++; if (mem_wd !== 32'h0) $display("FAIL reset_mem_wd got=%h exp=0", mem_wd); else passed++;
    total++; if (cpu_rd !== 32'h0 || dma_rd !== 32'h0) $display("FAIL reset_rd got=%h/%h exp=0/0", cpu_rd, dma_rd); else passed++;
    total++; if ({cpu_grant_cnt, dma_grant_cnt, conflict_cnt} !== 48'h0) $display("FAIL reset_cnt got=%h exp=0", {cpu_grant_cnt, dma_grant_cnt, conflict_cnt}); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_lone_read();
    set_ram(4, 32'hCAFE0001);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    total++; if (cpu_stall !== 1'b1) $display("FAIL lone_stall_t got=%b exp=1", cpu_stall); else passed++;
    tick();
    total++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) $display("FAIL lone_busy got=%h/%b exp=10/0", mem_addr, mem_we); else passed++;
    total++; if (cpu_ack !== 1'b0 || cpu_stall !== 1'b1) $display("FAIL lone_t1 got ack=%b stall=%b exp 0/1", cpu_ack, cpu_stall); else passed++;
    tick();
    total++; if (cpu_ack !== 1'b1 || cpu_stall !== 1'b0) $display("FAIL lone_t2 got ack=%b stall=%b exp 1/0", cpu_ack, cpu_stall); else passed++;
    total++; if (cpu_rd !== 32'hCAFE0001) $display("FAIL lone_rd got=%h exp=cafe0001", cpu_rd); else passed++;
    cpu_req = 1'b0;
    tick();
    total++; if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) $display("FAIL lone_after got=%b/%b exp=0/0", cpu_ack, dma_ack); else passed++;
  endtask

  task automatic test_simul_writes();
    int cpu_t = 0, dma_t = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wd = 32'h1111;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h24; dma_wd = 32'h2222;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h20) $display("FAIL simul_cpu_busy got=%b/%h exp=1/20", mem_we, mem_addr); else passed++;
      end
      if (c == 3) begin
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h24) $display("FAIL simul_dma_busy got=%b/%h exp=1/24", mem_we, mem_addr); else passed++;
      end
      if (cpu_ack) begin cpu_t = c; cpu_req = 1'b0; end
      if (dma_ack) begin dma_t = c; dma_req = 1'b0; end
    end
    total++; if (cpu_t != 2) $display("FAIL simul_cpu_ack_cycle got=%0d exp=2", cpu_t); else passed++;
    total++; if (dma_t != 4) $display("FAIL simul_dma_ack_cycle got=%0d exp=4", dma_t); else passed++;
    total++; if (ram[8] !== 32'h1111 || ram[9] !== 32'h2222) $display("FAIL simul_ram got=%h/%h exp=1111/2222", ram[8], ram[9]); else passed++;
  endtask

  task automatic test_starvation();
    int dma_t = 0, cpu_acks = 0;
    set_ram(12, 32'h5A5A0030);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h30;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 3) begin
        total++; if (cpu_stall !== 1'b1) $display("FAIL starve_stall got=%b exp=1", cpu_stall); else passed++;
      end
      if (cpu_ack) begin cpu_acks++; cpu_addr = cpu_addr + 32'h4; end
      if (dma_ack) begin
        dma_t = c;
        dma_req = 1'b0;
        total++; if (dma_rd !== 32'h5A5A0030) $display("FAIL starve_dma_rd got=%h exp=5a5a0030", dma_rd); else passed++;
      end
    end
    total++; if (dma_t != 4) $display("FAIL starve_dma_ack_cycle got=%0d exp=4", dma_t); else passed++;
    total++; if (cpu_acks < 3) $display("FAIL starve_cpu_progress got=%0d exp>=3", cpu_acks); else passed++;
    total++; if (dma_grant_cnt !== 16'(STATS ? m_dg : 0)) $display("FAIL starve_dma_cnt got=%0d exp=%0d", dma_grant_cnt, STATS ? m_dg : 0); else passed++;
    drain();
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wd = 32'hDEADBEEF;
    tick();
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h40) $display("FAIL rmid_busy got=%b/%h exp=1/40", mem_we, mem_addr); else passed++;
    reset = 1'b0;
    tick();
    total++; if (cpu_ack !== 1'b0 || mem_we !== 1'b0) $display("FAIL rmid_cut got ack=%b we=%b exp 0/0", cpu_ack, mem_we); else passed++;
    total++; if ({cpu_grant_cnt, dma_grant_cnt, conflict_cnt} !== 48'h0) $display("FAIL rmid_cnt got=%h exp=0", {cpu_grant_cnt, dma_grant_cnt, conflict_cnt}); else passed++;
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    total++; if (cpu_ack !== 1'b0 || mem_we !== 1'b0) $display("FAIL rmid_after got ack=%b we=%b exp 0/0", cpu_ack, mem_we); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd [3] = '{32'hB0B00000, 32'hB0B00001, 32'hB0B00002};
    int n = 0, dma_seen = 0;
    for (int i = 0; i < 3; i++) set_ram(i, exp_rd[i]);
    dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (dma_ack) dma_seen++;
      if (cpu_ack && n < 3) begin
        total++; if (cpu_rd !== exp_rd[n]) $display("FAIL b2b_rd%0d got=%h exp=%h", n, cpu_rd, exp_rd[n]); else passed++;
        n++;
        if (n < 3) cpu_addr = 32'(n * 4);
        else cpu_req = 1'b0;
      end
    end
    total++; if (n != 3) $display("FAIL b2b_count got=%0d exp=3", n); else passed++;
    total++; if (dma_seen != 0) $display("FAIL b2b_dma_ack got=%0d exp=0", dma_seen); else passed++;
  endtask

  task automatic test_stats();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'(r * 8);
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'(r * 8 + 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        if (cpu_ack) cpu_req = 1'b0;
        if (dma_ack) dma_req = 1'b0;
      end
    end
    total++; if (conflict_cnt !== 16'(STATS ? 3 : 0)) $display("FAIL stats_conflict got=%0d exp=%0d", conflict_cnt, STATS ? 3 : 0); else passed++;
    total++; if (cpu_grant_cnt !== 16'(STATS ? 3 : 0)) $display("FAIL stats_cpu got=%0d exp=%0d", cpu_grant_cnt, STATS ? 3 : 0); else passed++;
    total++; if (dma_grant_cnt !== 16'(STATS ? 3 : 0)) $display("FAIL stats_dma got=%0d exp=%0d", dma_grant_cnt, STATS ? 3 : 0); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset = $urandom_range(0, 63) != 0;
      tick();
      total++; if (cpu_ack !== (m_resp == 0)) $display("FAIL rnd_cpu_ack c=%0d got=%b exp=%b", c, cpu_ack, m_resp == 0); else passed++;
      total++; if (dma_ack !== (m_resp == 1)) $display("FAIL rnd_dma_ack c=%0d got=%b exp=%b", c, dma_ack, m_resp == 1); else passed++;
      total++; if (mem_we !== (m_busy >= 0 && m_we)) $display("FAIL rnd_mem_we c=%0d got=%b exp=%b", c, mem_we, m_busy >= 0 && m_we); else passed++;
      total++; if (mem_addr !== m_addr || mem_wd !== m_wd) $display("FAIL rnd_mem_bus c=%0d got=%h/%h exp=%h/%h", c, mem_addr, mem_wd, m_addr, m_wd); else passed++;
      total++; if (cpu_rd !== m_cpu_rd) $display("FAIL rnd_cpu_rd c=%0d got=%h exp=%h", c, cpu_rd, m_cpu_rd); else passed++;
      total++; if (dma_rd !== m_dma_rd) $display("FAIL rnd_dma_rd c=%0d got=%h exp=%h", c, dma_rd, m_dma_rd); else passed++;
      total++; if (cpu_stall !== (cpu_req && m_resp != 0)) $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, cpu_stall, cpu_req && m_resp != 0); else passed++;
      total++; if (cpu_grant_cnt !== 16'(STATS ? m_cg : 0)) $display("FAIL rnd_cpu_cnt c=%0d got=%0d exp=%0d", c, cpu_grant_cnt, STATS ? m_cg : 0); else passed++;
      total++; if (dma_grant_cnt !== 16'(STATS ? m_dg : 0)) $display("FAIL rnd_dma_cnt c=%0d got=%0d exp=%0d", c, dma_grant_cnt, STATS ? m_dg : 0); else passed++;
      total++; if (conflict_cnt !== 16'(STATS ? m_cf : 0)) $display("FAIL rnd_cfl_cnt c=%0d got=%0d exp=%0d", c, conflict_cnt, STATS ? m_cf : 0); else passed++;
      if (m_resp == 0) cpu_req = 1'b0;
      if (m_resp == 1) dma_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 1) == 1) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 32'($urandom_range(0, 63)) << 2; cpu_wd = $urandom;
      end
      if (!dma_req && $urandom_range(0, 1) == 1) begin
        dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
        dma_addr = 32'($urandom_range(0, 63)) << 2; dma_wd = $urandom;
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) set_ram(i, $urandom);
    test_reset();
    test_lone_read();
    test_simul_writes();
    drain();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    drain();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
